// File: rtl/gat_scheduler.sv
// GAT layer scheduler: loads the layer weights, then issues subgraphs to the
// compute pipeline while limiting how many are in flight. When every subgraph
// has been issued and completed, it pulses done_o.
module gat_scheduler #(
  parameter  int NUM_SUBGRAPHS = 2708,
  parameter  int MAX_INFLIGHT  = 4,
  localparam int SG_W          = $clog2(NUM_SUBGRAPHS),
  localparam int CRED_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  output logic            w_vld_o,
  input  logic            w_rdy_i,
  input  logic            h_vld_i,
  output logic            sg_start_o,
  output logic [SG_W-1:0] sg_idx_o,
  input  logic            sg_done_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  // The issue counter needs one extra code point so it can hold NUM_SUBGRAPHS
  // even when NUM_SUBGRAPHS is an exact power of two.
  localparam int CNT_W = $clog2(NUM_SUBGRAPHS + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CRED_W-1:0] inflight;

  logic              issue;
  logic              retire;
  logic              last_issue;
  logic              underflow;
  logic [CRED_W-1:0] inflight_nxt;

  // Issue/retire decisions and the next inflight value (credit accounting).
  always_comb begin
    issue        = (state == ISSUE) && h_vld_i
                   && (inflight < CRED_W'(MAX_INFLIGHT))
                   && (issue_cnt < CNT_W'(NUM_SUBGRAPHS));
    retire       = sg_done_i && (state != IDLE);
    last_issue   = issue && (issue_cnt == CNT_W'(NUM_SUBGRAPHS - 1));
    underflow    = retire && !issue && (inflight == '0);
    inflight_nxt = inflight;
    if (issue && !retire) begin
      inflight_nxt = inflight + CRED_W'(1);
    end else if (retire && !issue && (inflight != '0)) begin
      inflight_nxt = inflight - CRED_W'(1);
    end
  end

  // Control FSM with every output registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      inflight   <= '0;
      w_vld_o    <= 1'b0;
      sg_start_o <= 1'b0;
      sg_idx_o   <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      sg_start_o <= issue;
      done_o     <= 1'b0;
      inflight   <= inflight_nxt;
      if (issue) begin
        sg_idx_o  <= issue_cnt[SG_W-1:0];
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (underflow) begin
        err_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state     <= LOAD_W;
            w_vld_o   <= 1'b1;
            busy_o    <= 1'b1;
            issue_cnt <= '0;
            inflight  <= '0;
            err_o     <= 1'b0;
          end
        end
        LOAD_W: begin
          if (w_rdy_i) begin
            state   <= ISSUE;
            w_vld_o <= 1'b0;
          end
        end
        ISSUE: begin
          if (last_issue) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight_nxt == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          w_vld_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gat_scheduler.sv
// Directed self-checking bench for gat_scheduler (5 subgraphs, 2 credits).
module tb_gat_scheduler;

  localparam int NUM  = 5;
  localparam int MAXI = 2;
  localparam int SG_W = $clog2(NUM);

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start_i = 1'b0;
  logic            w_rdy_i = 1'b0;
  logic            h_vld_i = 1'b0;
  logic            sg_done_i = 1'b0;
  logic            w_vld_o;
  logic            sg_start_o;
  logic [SG_W-1:0] sg_idx_o;
  logic            busy_o;
  logic            done_o;
  logic            err_o;

  int checks = 0;
  int failures = 0;
  int model_inflight = 0;

  gat_scheduler #(.NUM_SUBGRAPHS(NUM), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .w_vld_o(w_vld_o),
    .w_rdy_i(w_rdy_i), .h_vld_i(h_vld_i), .sg_start_o(sg_start_o),
    .sg_idx_o(sg_idx_o), .sg_done_i(sg_done_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    rst_n = 1'b0; start_i = 1'b0; w_rdy_i = 1'b0; h_vld_i = 1'b0; sg_done_i = 1'b0;
    model_inflight = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Runs a layer to done_o, retiring one subgraph per cycle whenever any is outstanding.
  task automatic complete_layer(input int first_idx, input bit start_in_drain, output int dones);
    int  exp_idx;
    bit  seen;
    exp_idx = first_idx; dones = 0; seen = 1'b0;
    h_vld_i = 1'b1;
    for (int c = 0; c < 100 && !seen; c++) begin
      sg_done_i = (model_inflight > 0);
      if (sg_done_i) model_inflight--;
      tick();
      start_i = 1'b0;
      if (sg_start_o) begin
        checks++;
        if (sg_idx_o !== SG_W'(exp_idx)) begin
          failures++; $display("[TB] FAIL layer_idx: got %0d expected %0d", sg_idx_o, exp_idx);
        end
        exp_idx++; model_inflight++;
        checks++;
        if (model_inflight > MAXI) begin
          failures++; $display("[TB] FAIL layer_inflight: got %0d expected <= %0d", model_inflight, MAXI);
        end
        if (start_in_drain && exp_idx == NUM) start_i = 1'b1;
      end
      if (done_o) begin dones++; seen = 1'b1; end
    end
    sg_done_i = 1'b0; h_vld_i = 1'b0; start_i = 1'b0;
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL layer_timeout: got no done_o expected done_o within 100 cycles"); end
    checks++;
    if (exp_idx != NUM) begin failures++; $display("[TB] FAIL layer_issue_count: got %0d expected %0d", exp_idx, NUM); end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (w_vld_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_w_vld: got %b expected 0", w_vld_o); end
    checks++; if (sg_start_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_sg_start: got %b expected 0", sg_start_o); end
    checks++; if (sg_idx_o !== '0) begin failures++; $display("[TB] FAIL reset_sg_idx: got %0d expected 0", sg_idx_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
    hard_reset();
    tick(); tick();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_nominal();
    int cd[$];
    int exp_idx;
    int dones;
    bit seen;
    hard_reset();
    h_vld_i = 1'b1;
    pulse_start();
    checks++; if (w_vld_o !== 1'b1) begin failures++; $display("[TB] FAIL nominal_w_vld_on: got %b expected 1", w_vld_o); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("[TB] FAIL nominal_busy: got %b expected 1", busy_o); end
    tick(); tick(); tick();
    checks++; if (w_vld_o !== 1'b1) begin failures++; $display("[TB] FAIL nominal_w_vld_hold: got %b expected 1", w_vld_o); end
    w_rdy_i = 1'b1;
    exp_idx = 0; dones = 0; seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      sg_done_i = 1'b0;
      for (int k = 0; k < cd.size(); k++) cd[k]--;
      if (cd.size() > 0 && cd[0] == 0) begin
        void'(cd.pop_front());
        sg_done_i = 1'b1;
        model_inflight--;
      end
      tick();
      if (sg_start_o) begin
        checks++;
        if (sg_idx_o !== SG_W'(exp_idx)) begin
          failures++; $display("[TB] FAIL nominal_idx: got %0d expected %0d", sg_idx_o, exp_idx);
        end
        if (exp_idx == 0) begin
          checks++; if (w_vld_o !== 1'b0) begin failures++; $display("[TB] FAIL nominal_w_vld_off: got %b expected 0", w_vld_o); end
        end
        exp_idx++; model_inflight++; cd.push_back(3);
        checks++;
        if (model_inflight > MAXI) begin
          failures++; $display("[TB] FAIL nominal_inflight: got %0d expected <= %0d", model_inflight, MAXI);
        end
      end
      if (done_o) begin dones++; seen = 1'b1; end
    end
    sg_done_i = 1'b0;
    checks++; if (!seen) begin failures++; $display("[TB] FAIL nominal_timeout: got no done_o expected done_o"); end
    checks++; if (exp_idx != NUM) begin failures++; $display("[TB] FAIL nominal_issue_count: got %0d expected %0d", exp_idx, NUM); end
    tick();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL nominal_busy_after: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL nominal_done_width: got %b expected 0", done_o); end
    checks++; if (dones != 1) begin failures++; $display("[TB] FAIL nominal_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_credit_stall();
    int starts;
    hard_reset();
    w_rdy_i = 1'b1; h_vld_i = 1'b1;
    pulse_start();
    checks++; if (sg_start_o !== 1'b0) begin failures++; $display("[TB] FAIL stall_lat1: got %b expected 0", sg_start_o); end
    tick();
    checks++; if (sg_start_o !== 1'b0) begin failures++; $display("[TB] FAIL stall_lat2: got %b expected 0", sg_start_o); end
    checks++; if (w_vld_o !== 1'b0) begin failures++; $display("[TB] FAIL stall_w_vld_off: got %b expected 0", w_vld_o); end
    tick();
    checks++; if (sg_start_o !== 1'b1 || sg_idx_o !== 0) begin
      failures++; $display("[TB] FAIL stall_first_issue: got start=%b idx=%0d expected start=1 idx=0", sg_start_o, sg_idx_o);
    end
    tick();
    checks++; if (sg_start_o !== 1'b1 || sg_idx_o !== 1) begin
      failures++; $display("[TB] FAIL stall_second_issue: got start=%b idx=%0d expected start=1 idx=1", sg_start_o, sg_idx_o);
    end
    starts = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (sg_start_o) starts++;
    end
    checks++; if (starts != 0) begin failures++; $display("[TB] FAIL stall_no_issue: got %0d expected 0", starts); end
    sg_done_i = 1'b1;
    tick();
    sg_done_i = 1'b0;
    starts = 0;
    for (int c = 0; c < 6; c++) begin
      if (sg_start_o) begin
        starts++;
        checks++; if (sg_idx_o !== 2) begin failures++; $display("[TB] FAIL stall_resume_idx: got %0d expected 2", sg_idx_o); end
      end
      tick();
    end
    checks++; if (starts != 1) begin failures++; $display("[TB] FAIL stall_resume_count: got %0d expected 1", starts); end
  endtask

  task automatic test_simultaneous();
    hard_reset();
    w_rdy_i = 1'b1; h_vld_i = 1'b0;
    pulse_start();
    tick();
    h_vld_i = 1'b1;
    tick();
    checks++; if (sg_start_o !== 1'b1 || sg_idx_o !== 0) begin
      failures++; $display("[TB] FAIL simul_issue0: got start=%b idx=%0d expected start=1 idx=0", sg_start_o, sg_idx_o);
    end
    sg_done_i = 1'b1;
    tick();
    sg_done_i = 1'b0;
    checks++; if (sg_start_o !== 1'b1 || sg_idx_o !== 1) begin
      failures++; $display("[TB] FAIL simul_issue1: got start=%b idx=%0d expected start=1 idx=1", sg_start_o, sg_idx_o);
    end
    tick();
    checks++; if (sg_start_o !== 1'b1 || sg_idx_o !== 2) begin
      failures++; $display("[TB] FAIL simul_not_blocked: got start=%b idx=%0d expected start=1 idx=2", sg_start_o, sg_idx_o);
    end
    tick();
    checks++; if (sg_start_o !== 1'b0) begin failures++; $display("[TB] FAIL simul_credit_full: got %b expected 0", sg_start_o); end
  endtask

  task automatic test_spurious();
    int dones;
    hard_reset();
    w_rdy_i = 1'b1; h_vld_i = 1'b0;
    pulse_start();
    tick();
    sg_done_i = 1'b1;
    tick();
    sg_done_i = 1'b0;
    checks++; if (err_o !== 1'b1) begin failures++; $display("[TB] FAIL spur_err_set: got %b expected 1", err_o); end
    tick(); tick(); tick();
    checks++; if (err_o !== 1'b1) begin failures++; $display("[TB] FAIL spur_err_hold: got %b expected 1", err_o); end
    complete_layer(0, 1'b0, dones);
    checks++; if (dones != 1) begin failures++; $display("[TB] FAIL spur_done_count: got %0d expected 1", dones); end
    tick();
    checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++; $display("[TB] FAIL spur_err_idle: got err=%b busy=%b expected err=1 busy=0", err_o, busy_o);
    end
    pulse_start();
    checks++; if (err_o !== 1'b0) begin failures++; $display("[TB] FAIL spur_err_clear: got %b expected 0", err_o); end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    hard_reset();
    w_rdy_i = 1'b1; h_vld_i = 1'b1;
    pulse_start();
    tick(); tick();
    checks++; if (sg_idx_o !== 0 || sg_start_o !== 1'b1) begin failures++; $display("[TB] FAIL midrst_issue0: got idx=%0d expected 0", sg_idx_o); end
    sg_done_i = 1'b1;
    tick();
    sg_done_i = 1'b0;
    checks++; if (sg_idx_o !== 1 || sg_start_o !== 1'b1) begin failures++; $display("[TB] FAIL midrst_issue1: got idx=%0d expected 1", sg_idx_o); end
    tick();
    checks++; if (sg_idx_o !== 2 || sg_start_o !== 1'b1) begin failures++; $display("[TB] FAIL midrst_issue2: got idx=%0d expected 2", sg_idx_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({w_vld_o, sg_start_o, busy_o, done_o, err_o} !== 5'b0 || sg_idx_o !== '0) begin
      failures++; $display("[TB] FAIL midrst_outputs: got w=%b s=%b i=%0d b=%b d=%b e=%b expected all 0",
                           w_vld_o, sg_start_o, sg_idx_o, busy_o, done_o, err_o);
    end
    tick(); tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done_o !== 1'b0 || busy_o !== 1'b0 || sg_start_o !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL midrst_quiet: got %0d active cycles expected 0", bad); end
    pulse_start();
    tick(); tick();
    checks++; if (sg_start_o !== 1'b1 || sg_idx_o !== 0) begin
      failures++; $display("[TB] FAIL midrst_restart: got start=%b idx=%0d expected start=1 idx=0", sg_start_o, sg_idx_o);
    end
  endtask

  task automatic test_start_while_busy();
    int dones;
    int bad;
    hard_reset();
    w_rdy_i = 1'b1;
    pulse_start();
    complete_layer(0, 1'b1, dones);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done_o !== 1'b0) dones++;
      if (busy_o !== 1'b0 || w_vld_o !== 1'b0) bad++;
    end
    checks++; if (dones != 1) begin failures++; $display("[TB] FAIL busy_start_done_count: got %0d expected 1", dones); end
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL busy_start_restarted: got %0d busy cycles expected 0", bad); end
  endtask

  // Cycle-budget watchdog so a stuck DUT still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_nominal();
    test_credit_stall();
    test_simultaneous();
    test_spurious();
    test_reset_mid_run();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/gat_scheduler.md
GAT_SCHEDULER -- requirements
Module: gat_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_SUBGRAPHS, default 2708, meaning subgraphs per layer pass.
REQ-002 The block SHALL have parameter MAX_INFLIGHT, default 4, meaning maximum subgraphs issued but not yet completed.
REQ-003 The block SHALL derive SG_W = $clog2(NUM_SUBGRAPHS) and CRED_W = $clog2(MAX_INFLIGHT+1).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, using the ports below.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle layer start request.
- w_vld_o  output  1  weight-load request to the weight loader.
- w_rdy_i  input  1  weight loader finished, level.
- h_vld_i  input  1  feature data available for the next subgraph.
- sg_start_o  output  1  one-cycle subgraph issue pulse.
- sg_idx_o  output  SG_W  index of the issued subgraph, valid with sg_start_o.
- sg_done_i  input  1  one-cycle subgraph completion pulse.
- busy_o  output  1  high in any state except IDLE.
- done_o  output  1  one-cycle layer-complete pulse.
- err_o  output  1  sticky protocol-error flag.

Function
REQ-005 The FSM SHALL have five states: IDLE, LOAD_W, ISSUE, DRAIN and DONE.
REQ-006 All outputs SHALL be registered.
REQ-007 IDLE: on start_i = 1, the FSM SHALL go to LOAD_W next cycle, clear the issue and inflight counters, and clear err_o.
REQ-008 start_i SHALL be ignored in every state except IDLE.
REQ-009 LOAD_W: w_vld_o SHALL be 1 from the first LOAD_W cycle until w_rdy_i is sampled 1.
REQ-010 On sampling w_rdy_i = 1 in LOAD_W, the FSM SHALL go to ISSUE and w_vld_o SHALL be 0 from that next cycle.
REQ-011 ISSUE: an issue SHALL occur in a cycle where h_vld_i = 1, inflight < MAX_INFLIGHT and issued count < NUM_SUBGRAPHS.
REQ-012 An issue SHALL produce sg_start_o = 1 in the following cycle, with sg_idx_o equal to the issue count before increment.
REQ-013 An issue SHALL increment both the issue counter and the inflight counter.
REQ-014 sg_start_o SHALL pulse at most once per cycle, and back-to-back issues on consecutive cycles SHALL be allowed.
REQ-015 The issue counter SHALL hold its value after reaching NUM_SUBGRAPHS, with no wrap-around.
REQ-016 sg_done_i = 1 SHALL decrement inflight in any state except IDLE.
REQ-017 An issue and sg_done_i in the same cycle SHALL leave inflight unchanged.
REQ-018 sg_done_i = 1 with inflight = 0 and no same-cycle issue SHALL leave inflight at 0 and set err_o.
REQ-019 sg_done_i in IDLE SHALL be ignored and SHALL NOT set err_o.
REQ-020 When the final issue (index NUM_SUBGRAPHS-1) is made, the FSM SHALL go to DRAIN next cycle.
REQ-021 DRAIN: once inflight = 0, including a decrement to 0 in the current cycle, the FSM SHALL go to DONE.
REQ-022 DONE: done_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 busy_o SHALL be 0 in IDLE and 1 in LOAD_W, ISSUE, DRAIN and DONE.
REQ-024 Minimum latency from start_i to first sg_start_o, with w_rdy_i and h_vld_i already high, SHALL be 3 cycles.
REQ-025 The inflight counter SHALL be CRED_W bits wide, SHALL never exceed MAX_INFLIGHT, and SHALL never underflow.

Reset
REQ-026 On rst_n = 0, the FSM SHALL enter IDLE immediately, independent of clk.
REQ-027 On rst_n = 0, all counters SHALL clear to 0.
REQ-028 During reset, w_vld_o, sg_start_o, sg_idx_o, busy_o, done_o and err_o SHALL all be 0.
REQ-029 Reset asserted mid-layer SHALL abandon all inflight state, and no done_o SHALL follow.
REQ-030 After reset deasserts, the block SHALL wait for a new start_i.

Verification (NUM_SUBGRAPHS=5, MAX_INFLIGHT=2)
REQ-031 Nominal case: start_i, w_rdy_i 4 cycles later, h_vld_i=1, each sg_done_i 3 cycles after its issue.
- Required: sg_idx_o 0..4 in order, inflight never > 2, exactly one done_o, then busy_o=0.
REQ-032 Credit stall: issue 2, withhold sg_done_i 10 cycles.
- Required: no sg_start_o in those cycles.
- One sg_done_i -> exactly one further issue.
REQ-033 Simultaneous issue and done: sg_done_i coincident with an issue at inflight=1.
- Required: inflight stays 1, and the next issue is not blocked.
REQ-034 Spurious completion: sg_done_i in ISSUE with inflight=0.
- Required: err_o=1 and held until the next start_i in IDLE, inflight=0.
REQ-035 Reset mid-run: rst_n=0 in ISSUE after 3 issues.
- Required: all outputs 0 that cycle, no done_o.
- A subsequent start_i restarts at sg_idx_o=0.
REQ-036 Start while busy: start_i pulsed in DRAIN.
- Required: ignored, and exactly one done_o.
